instr_fetcher: RTL

- Front end of the core: owns the program counter, issues word-addressed requests to instruction memory and delivers fetched instructions with their PC to the decoder over a valid/ready handshake.
- Accepts branch and jump redirects, which are the executer's `JUMP_DEST` qualified by a valid strobe.
- Supports up to two in-flight memory requests.
- Buffers up to two returned instructions.
- Discards responses that belong to a superseded path after a redirect.

---
 rtl/instr_fetcher.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instr_fetcher.sv
// Instruction fetch front end: owns the PC, keeps up to two memory requests in flight and
// buffers up to two returned instructions for the decoder, dropping responses from a stale path.
module instr_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC
);

  logic [31:0] pc;
  logic [31:0] addr_q [2];
  logic [1:0]  inflight;
  logic [1:0]  kill;
  logic [1:0]  fifo_count;
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc [2];

  logic        credit_ok;
  logic        grant;
  logic        resp;
  logic        discard;
  logic        push;
  logic        pop;
  logic        aq_wr;
  logic        fifo_wr;
  logic [1:0]  inflight_nxt;
  logic [1:0]  kill_nxt;
  logic [1:0]  count_nxt;

  // Every buffered or outstanding instruction holds one of two credits.
  assign credit_ok   = ({1'b0, inflight} + {1'b0, fifo_count}) < 3'd2;
  assign IMEM_REQ    = !RST && !REDIRECT_VALID && credit_ok;
  assign IMEM_ADDR   = pc;
  assign INSTR_VALID = !RST && !REDIRECT_VALID && (fifo_count != 2'd0);
  assign INSTR       = fifo_instr[0];
  assign INSTR_PC    = fifo_pc[0];

  // A response with nothing outstanding is a protocol error and is dropped silently.
  assign grant   = IMEM_REQ && IMEM_GNT;
  assign resp    = IMEM_RVALID && (inflight != 2'd0);
  assign discard = (kill != 2'd0) || REDIRECT_VALID;
  assign push    = resp && !discard;
  assign pop     = INSTR_VALID && INSTR_READY;

  // Both queues shift toward slot 0, so the write slot is the occupancy left after a pop.
  assign aq_wr   = resp ? (inflight == 2'd2) : (inflight == 2'd1);
  assign fifo_wr = pop ? (fifo_count == 2'd2) : (fifo_count == 2'd1);

  always_comb begin
    inflight_nxt = inflight;
    kill_nxt     = kill;
    count_nxt    = fifo_count;
    if (grant && !resp) begin
      inflight_nxt = inflight + 2'd1;
    end else if (!grant && resp) begin
      inflight_nxt = inflight - 2'd1;
    end
    // On a redirect everything still outstanding after this cycle belongs to the old path.
    if (REDIRECT_VALID) begin
      kill_nxt = inflight - {1'b0, resp};
    end else if (resp && (kill != 2'd0)) begin
      kill_nxt = kill - 2'd1;
    end
    if (REDIRECT_VALID) begin
      count_nxt = 2'd0;
    end else if (push && !pop) begin
      count_nxt = fifo_count + 2'd1;
    end else if (!push && pop) begin
      count_nxt = fifo_count - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc            <= RESET_PC;
      inflight      <= 2'd0;
      kill          <= 2'd0;
      fifo_count    <= 2'd0;
      addr_q[0]     <= 32'h0;
      addr_q[1]     <= 32'h0;
      fifo_instr[0] <= 32'h0;
      fifo_instr[1] <= 32'h0;
      fifo_pc[0]    <= 32'h0;
      fifo_pc[1]    <= 32'h0;
    end else begin
      if (REDIRECT_VALID) begin
        pc <= REDIRECT_PC;
      end else if (grant) begin
        pc <= pc + 32'd1;
      end
      inflight   <= inflight_nxt;
      kill       <= kill_nxt;
      fifo_count <= count_nxt;
      if (resp) begin
        addr_q[0] <= addr_q[1];
      end
      if (grant) begin
        addr_q[aq_wr] <= pc;
      end
      if (pop) begin
        fifo_instr[0] <= fifo_instr[1];
        fifo_pc[0]    <= fifo_pc[1];
      end
      if (push) begin
        fifo_instr[fifo_wr] <= IMEM_RDATA;
        fifo_pc[fifo_wr]    <= addr_q[0];
      end
    end
  end

endmodule
